// File: rtl/axis_width_split_pkg.sv
// Shared types and helpers for the axis_width_split wide-to-narrow AXI-stream downsizer.
package axis_width_split_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } state_e;

  function automatic int calc_ratio(input int isize, input int osize);
    return isize / osize;
  endfunction

  // Width 1 is used for degenerate ratios so that declarations stay legal until the config check fires.
  function automatic int calc_cnt_w(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

  // Maps an emission-order position to the physical slice index of the word.
  function automatic int slice_index(input int cnt, input int ratio, input int lsb_first);
    return (lsb_first != 0) ? cnt : (ratio - 1 - cnt);
  endfunction

endpackage

// File: rtl/axis_width_split.sv
// Wide-to-narrow AXI-stream downsizer: each ISIZE word leaves as ISIZE/OSIZE OSIZE-bit beats.
// Optional macro AXIS_WIDTH_SPLIT_KEEP_EN adds wr_keep to truncate the final word of a packet.
module axis_width_split
  import axis_width_split_pkg::*;
#(
  parameter int ISIZE     = 64,
  parameter int OSIZE     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [ISIZE-1:0] wr_data,
  input  logic             wr_vld,
  output logic             wr_ready,
  input  logic             wr_last,
`ifdef AXIS_WIDTH_SPLIT_KEEP_EN
  input  logic [ISIZE/OSIZE-1:0] wr_keep,
`endif
  output logic [OSIZE-1:0] rd_data,
  output logic             rd_vld,
  input  logic             rd_ready,
  output logic             rd_last
);

  localparam int RATIO = calc_ratio(ISIZE, OSIZE);
  localparam int CNT_W = calc_cnt_w(RATIO);

  if (((ISIZE % OSIZE) != 0) || (RATIO < 2)) begin : g_bad_cfg
    $error("axis_width_split: ISIZE must be a multiple of OSIZE with ISIZE/OSIZE >= 2");
  end

  state_e                        state_r;
  state_e                        state_nxt_s;
  logic [RATIO-1:0][OSIZE-1:0]   hold_r;
  logic                          last_r;
  logic [CNT_W-1:0]              cnt_r;
  logic [CNT_W-1:0]              stop_r;
  logic [CNT_W-1:0]              stop_s;
  logic [CNT_W-1:0]              sel_s;
  logic                          rst_done_r;
  logic                          final_s;
  logic                          rd_fire_s;
  logic                          wr_fire_s;

  assign final_s   = (cnt_r == stop_r);
  assign rd_fire_s = rd_vld & rd_ready;
  assign wr_fire_s = wr_vld & wr_ready;
  assign sel_s     = CNT_W'(slice_index(int'(cnt_r), RATIO, LSB_FIRST));

  // Emission position of the final beat for the word currently offered on the input.
`ifdef AXIS_WIDTH_SPLIT_KEEP_EN
  always_comb begin
    stop_s = '0;
    if (wr_last) begin
      for (int c = 0; c < RATIO; c++) begin
        stop_s = wr_keep[CNT_W'(slice_index(c, RATIO, LSB_FIRST))] ? CNT_W'(c) : stop_s;
      end
    end else begin
      stop_s = CNT_W'(RATIO - 1);
    end
  end
`else
  always_comb begin
    stop_s = CNT_W'(RATIO - 1);
  end
`endif

  // Holds wr_ready low until the first clock edge after reset is released.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rst_done_r <= 1'b0;
    end else begin
      rst_done_r <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: a final-beat handshake with a new word pending stays BUSY, so words chain with no bubble.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY: begin
        if (wr_fire_s) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = EMPTY;
        end
      end
      BUSY: begin
        if (rd_fire_s && final_s && !wr_fire_s) begin
          state_nxt_s = EMPTY;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: state_nxt_s = EMPTY;
    endcase
  end

  // FSM outputs; wr_ready intentionally sees rd_ready combinationally to allow back-to-back words.
  always_comb begin
    rd_vld   = 1'b0;
    wr_ready = 1'b0;
    case (state_r)
      EMPTY: begin
        rd_vld   = 1'b0;
        wr_ready = rst_done_r;
      end
      BUSY: begin
        rd_vld   = 1'b1;
        wr_ready = rst_done_r & final_s & rd_ready;
      end
      default: begin
        rd_vld   = 1'b0;
        wr_ready = 1'b0;
      end
    endcase
    rd_last = last_r & final_s & rd_vld;
  end

  // Word capture and slice counter; the counter wraps to 0 on the final beat so it never leaves range.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      hold_r <= '0;
      last_r <= 1'b0;
      cnt_r  <= '0;
      stop_r <= '0;
    end else if (wr_fire_s) begin
      hold_r <= wr_data;
      last_r <= wr_last;
      cnt_r  <= '0;
      stop_r <= stop_s;
    end else if (rd_fire_s) begin
      cnt_r  <= final_s ? CNT_W'(0) : (cnt_r + CNT_W'(1));
    end else begin
      cnt_r  <= cnt_r;
    end
  end

  // Output slice is selected from the holding register only, never from wr_data.
  always_comb begin
    rd_data = hold_r[sel_s];
  end

endmodule

// File: tb/tb_axis_width_split.sv
// Directed self-checking bench for axis_width_split (32->8, LSB-first and MSB-first instances).
module tb_axis_width_split;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;

  logic [31:0] wr_data  = 32'h0;
  logic        wr_vld   = 1'b0;
  logic        wr_last  = 1'b0;
  logic        wr_ready;
  logic [7:0]  rd_data;
  logic        rd_vld;
  logic        rd_ready = 1'b1;
  logic        rd_last;

  logic [31:0] m_wr_data  = 32'h0;
  logic        m_wr_vld   = 1'b0;
  logic        m_wr_last  = 1'b0;
  logic        m_wr_ready;
  logic [7:0]  m_rd_data;
  logic        m_rd_vld;
  logic        m_rd_ready = 1'b1;
  logic        m_rd_last;

`ifdef AXIS_WIDTH_SPLIT_KEEP_EN
  logic [3:0]  wr_keep   = 4'hF;
  logic [3:0]  m_wr_keep = 4'hF;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  axis_width_split #(.ISIZE(32), .OSIZE(8), .LSB_FIRST(1)) dut (
    .clock    (clock),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_vld   (wr_vld),
    .wr_ready (wr_ready),
    .wr_last  (wr_last),
`ifdef AXIS_WIDTH_SPLIT_KEEP_EN
    .wr_keep  (wr_keep),
`endif
    .rd_data  (rd_data),
    .rd_vld   (rd_vld),
    .rd_ready (rd_ready),
    .rd_last  (rd_last)
  );

  axis_width_split #(.ISIZE(32), .OSIZE(8), .LSB_FIRST(0)) dut_m (
    .clock    (clock),
    .rst      (rst),
    .wr_data  (m_wr_data),
    .wr_vld   (m_wr_vld),
    .wr_ready (m_wr_ready),
    .wr_last  (m_wr_last),
`ifdef AXIS_WIDTH_SPLIT_KEEP_EN
    .wr_keep  (m_wr_keep),
`endif
    .rd_data  (m_rd_data),
    .rd_vld   (m_rd_vld),
    .rd_ready (m_rd_ready),
    .rd_last  (m_rd_last)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offers one word, then checks nbeats output beats (byte i of exp is beat i) with rd_ready held high.
  task automatic send_word(input logic [31:0] data, input logic last, input logic [3:0] keep,
                           input int nbeats, input logic [31:0] exp);
    wr_data = data;
    wr_last = last;
`ifdef AXIS_WIDTH_SPLIT_KEEP_EN
    wr_keep = keep;
`endif
    wr_vld  = 1'b1;
    rd_ready = 1'b1;
    check_eq("accept_ready", {63'd0, wr_ready}, 64'd1);
    check_eq("pre_vld", {63'd0, rd_vld}, 64'd0);
    tick();
    wr_vld = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      check_eq("beat_vld", {63'd0, rd_vld}, 64'd1);
      check_eq("beat_data", {56'd0, rd_data}, {56'd0, exp[i*8 +: 8]});
      check_eq("beat_last", {63'd0, rd_last}, {63'd0, (last && (i == nbeats - 1))});
      tick();
    end
    check_eq("post_vld", {63'd0, rd_vld}, 64'd0);
  endtask

  initial begin
    logic [15:0] pat;
    logic [31:0] exp_b;
    int          idx;

    // Reset state
    rst = 1'b1;
    tick();
    check_eq("rst_vld", {63'd0, rd_vld}, 64'd0);
    check_eq("rst_last", {63'd0, rd_last}, 64'd0);
    check_eq("rst_data", {56'd0, rd_data}, 64'd0);
    check_eq("rst_wr_ready", {63'd0, wr_ready}, 64'd0);
    rst = 1'b0;
    #1;
    check_eq("rel_wr_ready0", {63'd0, wr_ready}, 64'd0);
    tick();
    check_eq("rel_wr_ready1", {63'd0, wr_ready}, 64'd1);

    // Single last word, LSB first
    send_word(32'hDDCCBBAA, 1'b1, 4'hF, 4, 32'hDDCCBBAA);

    // Back-to-back words with no bubble
    wr_data = 32'h04030201;
    wr_last = 1'b0;
    wr_vld  = 1'b1;
    tick();
    wr_data = 32'h08070605;
    wr_last = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("b2b_vld", {63'd0, rd_vld}, 64'd1);
      check_eq("b2b_data", {56'd0, rd_data}, 64'(i + 1));
      check_eq("b2b_wr_ready", {63'd0, wr_ready}, {63'd0, (i == 3 || i == 7)});
      check_eq("b2b_last", {63'd0, rd_last}, {63'd0, (i == 7)});
      tick();
      if (i == 3) wr_vld = 1'b0;
    end
    check_eq("b2b_idle", {63'd0, rd_vld}, 64'd0);

    // Back-pressure: output held stable, no slice lost or duplicated
    wr_data = 32'h44332211;
    wr_last = 1'b1;
    wr_vld  = 1'b1;
    tick();
    wr_vld = 1'b0;
    pat   = 16'b1011_0101_1001_1001;
    exp_b = 32'h44332211;
    idx   = 0;
    for (int k = 0; k < 16 && idx < 4; k++) begin
      rd_ready = pat[k];
      #1;
      check_eq("stall_vld", {63'd0, rd_vld}, 64'd1);
      check_eq("stall_data", {56'd0, rd_data}, {56'd0, exp_b[idx*8 +: 8]});
      check_eq("stall_wr_ready", {63'd0, wr_ready}, {63'd0, (idx == 3 && pat[k])});
      tick();
      if (pat[k]) idx++;
    end
    check_eq("stall_done", 64'(idx), 64'd4);
    check_eq("stall_idle", {63'd0, rd_vld}, 64'd0);
    rd_ready = 1'b1;

    // MSB-first instance
    m_wr_data = 32'h11223344;
    m_wr_last = 1'b1;
    m_wr_vld  = 1'b1;
    tick();
    m_wr_vld = 1'b0;
    exp_b = 32'h44332211;
    for (int i = 0; i < 4; i++) begin
      check_eq("msb_vld", {63'd0, m_rd_vld}, 64'd1);
      check_eq("msb_data", {56'd0, m_rd_data}, {56'd0, exp_b[i*8 +: 8]});
      check_eq("msb_last", {63'd0, m_rd_last}, {63'd0, (i == 3)});
      tick();
    end
    check_eq("msb_idle", {63'd0, m_rd_vld}, 64'd0);

    // Reset in the middle of a word
    wr_data = 32'hAABBCCDD;
    wr_last = 1'b1;
    wr_vld  = 1'b1;
    tick();
    wr_vld = 1'b0;
    check_eq("mid_b0", {56'd0, rd_data}, 64'hDD);
    tick();
    check_eq("mid_b1", {56'd0, rd_data}, 64'hCC);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_vld", {63'd0, rd_vld}, 64'd0);
    check_eq("mid_rst_wr_ready", {63'd0, wr_ready}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    send_word(32'h00000001, 1'b1, 4'hF, 4, 32'h00000001);

`ifdef AXIS_WIDTH_SPLIT_KEEP_EN
    send_word(32'h00332211, 1'b1, 4'b0111, 3, 32'h00332211);
    send_word(32'h00332211, 1'b1, 4'b0000, 1, 32'h00000011);
    send_word(32'h00332211, 1'b0, 4'b0001, 4, 32'h00332211);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_width_split.md
Name: axis_width_split

Overview:
- Wide-to-narrow AXI-stream downsizer. Each accepted ISIZE-bit word is emitted as RATIO = ISIZE/OSIZE consecutive OSIZE-bit beats.
- Sits on the downstream side of wide datapaths (DMA, FIFO read ports) and feeds narrow byte/half-word consumers.
- Packet boundaries are preserved: rd_last marks the final slice of a word that arrived with wr_last.
- Full throughput: one narrow beat per cycle, with no bubble between input words.

Parameters:
- ISIZE, 64, input data width; must be an integer multiple of OSIZE.
- OSIZE, 8, output data width; RATIO = ISIZE/OSIZE must be >= 2 (elaboration-time error otherwise).
- LSB_FIRST, 1, 1 = slice 0 is wr_data[OSIZE-1:0] and goes out first; 0 = most-significant slice goes out first.

Ports:
- clock  input  1  single clock for all logic.
- rst  input  1  asynchronous, active-high reset.
- wr_data  input  ISIZE  wide input word.
- wr_vld  input  1  input valid.
- wr_ready  output  1  input ready.
- wr_last  input  1  input word is the last of its packet.
- rd_data  output  OSIZE  narrow output slice.
- rd_vld  output  1  output valid.
- rd_ready  input  1  output ready.
- rd_last  output  1  final slice of a last word.

Behaviour:
- Reset, asynchronous and active-high:
  - rd_vld=0, rd_last=0, rd_data=0.
  - Slice counter cnt=0, holding register=0, stored last flag=0.
  - wr_ready=1 one cycle after rst deasserts; wr_ready is 0 while rst is high.
- Storage: one ISIZE holding register, one last flag, and cnt of width $clog2(RATIO) that indexes the current slice.
- States:
  - EMPTY: rd_vld=0, wr_ready=1.
  - BUSY: rd_vld=1.
- Transitions:
  - EMPTY -> BUSY on wr_vld & wr_ready. The word and last flag are captured and cnt=0. rd_vld rises the next cycle (latency 1).
  - BUSY: each rd_vld & rd_ready increments cnt.
  - Final slice is cnt==RATIO-1. When it is accepted:
    - if wr_vld, capture the new word in the same cycle, set cnt=0 and stay BUSY (back-to-back, no bubble);
    - otherwise go to EMPTY.
- wr_ready = EMPTY | (cnt==RATIO-1 & rd_ready). This combinational path from rd_ready is allowed and documented.
- rd_data = slice cnt (LSB_FIRST=1) or slice RATIO-1-cnt (LSB_FIRST=0). It is registered-select from the holding register and must not depend combinationally on wr_data.
- rd_last = stored last flag & (cnt==last slice index).
- rd_data and rd_last are held stable while rd_vld & !rd_ready (AXI rule). rd_vld never drops without a handshake.
- wr_last on a single-word packet produces RATIO beats, with only the final one carrying rd_last.
- Reset mid-word discards the held word and all of its remaining slices. The next packet starts clean.

Optional Feature:
- Macro: AXIS_WIDTH_SPLIT_KEEP_EN.
- When defined:
  - Adds input port wr_keep [RATIO-1:0], one bit per slice, sampled with wr_data.
  - On words with wr_last=1, emission stops after the highest set keep bit (in emission order); rd_last is asserted on that slice.
  - wr_keep==0 on a last word is treated as keep[first slice]=1.
  - keep is ignored on non-last words, which always emit all RATIO slices.
  - Keep must be contiguous from the first slice; non-contiguous keep is undefined.
- When undefined: no wr_keep port, and every word emits RATIO slices.

Decomposition:
- Package axis_width_split_pkg holds:
  - a RATIO/count-width calculation function;
  - a state enum {EMPTY, BUSY};
  - a slice-index helper that applies LSB_FIRST.
- No sub-module: the slice mux and counter fit in one module of about 150-250 lines.

Test Plan:
- ISIZE=32, OSIZE=8, LSB_FIRST=1, word 0xDDCCBBAA with wr_last=1, rd_ready=1 -> rd_data AA,BB,CC,DD on 4 consecutive cycles; rd_last only on DD; rd_vld first seen 1 cycle after the input handshake.
- Two back-to-back words 0x04030201 and 0x08070605 with rd_ready=1 -> 8 contiguous beats 01..08 with no idle cycle; wr_ready pulses only on the cycles of beats 04 and 08.
- rd_ready toggled 1,0,0,1,... -> rd_data and rd_vld held stable through stalls; no slice lost or duplicated; wr_ready stays 0 until the final slice is accepted.
- LSB_FIRST=0, word 0x11223344 -> output order 11,22,33,44.
- rst asserted after 2 of 4 slices of 0xAABBCCDD -> rd_vld=0 immediately (asynchronous); after release, word 0x00000001 yields 01,00,00,00 only.
- With AXIS_WIDTH_SPLIT_KEEP_EN, ISIZE=32/OSIZE=8, last word 0x00332211 with wr_keep=4'b0111 -> 3 beats 11,22,33, rd_last on 33; wr_keep=0 -> single beat 11 with rd_last.
